// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL clock-enable supervisor.
// Holds the FSM state encodings and a counter-width helper.
package pll_sup_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] SETTLE    = 2'd1;
    localparam logic [1:0] RELEASE   = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    // Bits needed to hold values 0..n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nco_ch.sv
// One NCO channel: increment register plus phase accumulator.
// Ports: clk, rst (sync, high), clr (hold acc at 0), load/incr
// (capture a new increment), ena (registered accumulator carry).
module nco_ch
    import pll_sup_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] incr,
    output logic                 ena
);

    logic [ACC_WIDTH-1:0] inc_reg;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_reg <= '0;
            acc     <= '0;
            ena     <= 1'b0;
        end else begin
            // Loads are honoured even while the channel is held in reset.
            if (load) begin
                inc_reg <= incr;
            end
            if (clr) begin
                acc <= '0;
                ena <= 1'b0;
            end else begin
                acc <= sum[ACC_WIDTH-1:0];
                ena <= sum[ACC_WIDTH];
            end
        end
    end

endmodule

// File: rtl/pll_clkena_supervisor.sv
// PLL lock qualifier, staggered channel reset sequencer and NCO enables.
// Ports: refclk/rst, pll_locked (async), incr/incr_load, lock_clear;
// outputs ch_rst, ena, ready (RUN state) and sticky lock_lost.
module pll_clkena_supervisor
    import pll_sup_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 24,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGGER     = 16
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          pll_locked,
    input  logic [CHANNELS*ACC_WIDTH-1:0] incr,
    input  logic [CHANNELS-1:0]           incr_load,
    input  logic                          lock_clear,
    output logic [CHANNELS-1:0]           ch_rst,
    output logic [CHANNELS-1:0]           ena,
    output logic                          ready,
    output logic                          lock_lost
);

    localparam int SCW      = cnt_width(LOCK_CYCLES);
    localparam int LAST_REL = (CHANNELS - 1) * STAGGER;
    localparam int STW      = cnt_width(LAST_REL);

    logic [1:0]     sync_q;
    logic           lk;
    logic [1:0]     state;
    logic [SCW-1:0] settle_cnt;
    logic [SCW-1:0] settle_nxt;
    logic [STW-1:0] stag_cnt;
    logic           drop;

    assign lk         = sync_q[1];
    assign settle_nxt = settle_cnt + SCW'(1);
    assign ready      = (state == RUN);

    // Lock lost outside WAIT_LOCK: everything falls back on this edge.
    assign drop = !lk && (state != WAIT_LOCK);

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q     <= '0;
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            stag_cnt   <= '0;
            ch_rst     <= '1;
            lock_lost  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};

            // A new loss outranks a clear in the same cycle.
            if (state == RUN && !lk) begin
                lock_lost <= 1'b1;
            end else if (lock_clear) begin
                lock_lost <= 1'b0;
            end

            if (drop) begin
                state      <= WAIT_LOCK;
                settle_cnt <= '0;
                stag_cnt   <= '0;
                ch_rst     <= '1;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        settle_cnt <= '0;
                        stag_cnt   <= '0;
                        if (lk) begin
                            // The WAIT_LOCK cycle with lk=1 is the first
                            // locked cycle of the run.
                            state <= (LOCK_CYCLES == 1) ? RELEASE : SETTLE;
                        end
                    end
                    SETTLE: begin
                        settle_cnt <= settle_nxt;
                        if (settle_nxt == SCW'(LOCK_CYCLES - 1)) begin
                            state    <= RELEASE;
                            stag_cnt <= '0;
                        end
                    end
                    RELEASE: begin
                        stag_cnt <= stag_cnt + STW'(1);
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (stag_cnt == STW'(i * STAGGER)) begin
                                ch_rst[i] <= 1'b0;
                            end
                        end
                        if (stag_cnt == STW'(LAST_REL)) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state  <= WAIT_LOCK;
                        ch_rst <= '1;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        nco_ch #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_nco (
            .clk (refclk),
            .rst (rst),
            .clr (ch_rst[g] | drop),
            .load(incr_load[g]),
            .incr(incr[g*ACC_WIDTH +: ACC_WIDTH]),
            .ena (ena[g])
        );
    end

endmodule
